// File: rtl/sub_iter_clk_if.sv
// Operand/result bundle for the iterative subtractor: request side
// (start, a, b, bi) and result side (d, bo, ov, busy, done).
interface sub_iter_clk_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bi;
    logic [WIDTH-1:0] d;
    logic             bo;
    logic             ov;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, bi,
        input  d, bo, ov, busy, done
    );

    modport slave (
        input  start, a, b, bi,
        output d, bo, ov, busy, done
    );
endinterface

// File: rtl/sub_iter_clk.sv
// Clocked multi-cycle subtractor: d = a - b - bi, computed one SLICE-bit
// group per clock as a + ~b + ~bi through a SLICE-bit carry-lookahead slice.
module sub_iter_clk #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic         clk,
    input  logic         reset,
    sub_iter_clk_if.slave bus
);
    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   nb_q, nb_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bo_q, bo_d;
    logic               ov_q, ov_d;

    logic [SLICE-1:0]   a_sl, nb_sl, sum_sl;
    logic [SLICE-1:0]   cla_g, cla_p;
    logic [SLICE:0]     cla_c;
    logic               cla_acc, cla_term;
    logic               carry_out;

    // Pick the operand slices addressed by the slice counter
    always_comb begin
        a_sl  = '0;
        nb_sl = '0;
        for (int unsigned s = 0; s < NSLICE; s++) begin
            if (cnt_q == CNT_W'(s)) begin
                a_sl  = a_q[s*SLICE +: SLICE];
                nb_sl = nb_q[s*SLICE +: SLICE];
            end
        end
    end

    // SLICE-bit carry lookahead: each carry is the flat OR of generate terms
    // propagated to it, plus the slice carry-in propagated through all lower bits
    always_comb begin
        cla_g    = a_sl & nb_sl;
        cla_p    = a_sl ^ nb_sl;
        cla_c    = '0;
        cla_c[0] = carry_q;
        cla_acc  = 1'b0;
        cla_term = 1'b0;
        for (int unsigned i = 0; i < SLICE; i++) begin
            cla_term = carry_q;
            for (int unsigned m = 0; m <= i; m++) begin
                cla_term = cla_term & cla_p[m];
            end
            cla_acc = cla_term;
            for (int unsigned k = 0; k <= i; k++) begin
                cla_term = cla_g[k];
                for (int unsigned m = k + 1; m <= i; m++) begin
                    cla_term = cla_term & cla_p[m];
                end
                cla_acc = cla_acc | cla_term;
            end
            cla_c[i+1] = cla_acc;
        end
        sum_sl    = cla_p ^ cla_c[SLICE-1:0];
        carry_out = cla_c[SLICE];
    end

    // Next-state, operand capture and slice write-back
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        nb_d    = nb_q;
        carry_d = carry_q;
        diff_d  = diff_q;
        bo_d    = bo_q;
        ov_d    = ov_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    nb_d    = ~bus.b;
                    carry_d = ~bus.bi;
                    cnt_d   = '0;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                for (int unsigned s = 0; s < NSLICE; s++) begin
                    if (cnt_q == CNT_W'(s)) begin
                        diff_d[s*SLICE +: SLICE] = sum_sl;
                    end
                end
                carry_d = carry_out;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NSLICE - 1)) begin
                    // nb holds ~b, so "a and b signs differ" is a MSB == nb MSB
                    bo_d    = ~carry_out;
                    ov_d    = (a_q[WIDTH-1] == nb_q[WIDTH-1]) &
                              (sum_sl[SLICE-1] != a_q[WIDTH-1]);
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            nb_q    <= '0;
            carry_q <= 1'b0;
            diff_q  <= '0;
            bo_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            nb_q    <= nb_d;
            carry_q <= carry_d;
            diff_q  <= diff_d;
            bo_q    <= bo_d;
            ov_q    <= ov_d;
        end
    end

    assign bus.d    = diff_q;
    assign bus.bo   = bo_q;
    assign bus.ov   = ov_q;
    assign bus.busy = (state_q == CALC);
    assign bus.done = (state_q == DONE);
endmodule

// File: tb/tb_sub_iter_clk.sv
// Self-checking bench for sub_iter_clk: directed vector table, protocol
// corner sequences and randomized operands against a plain arithmetic model.
module tb_sub_iter_clk;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    sub_iter_clk_if #(.WIDTH(32)) bus ();

    sub_iter_clk #(.WIDTH(32), .SLICE(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bi;
        logic [31:0] exp_d;
        logic        exp_bo;
        logic        exp_ov;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: unsigned difference with borrow, and signed range overflow
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic bi,
                                  output logic [31:0] d, output logic bo, output logic ov);
        logic [32:0] w;
        longint      r;
        w  = {1'b0, a} - {1'b0, b} - {32'd0, bi};
        d  = w[31:0];
        bo = w[32];
        r  = longint'($signed(a)) - longint'($signed(b)) - longint'(bi);
        ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    // Present operands at the current negedge; the next posedge accepts them
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic bi);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.bi    = bi;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.bi    = 1'($urandom);
    endtask

    // From the negedge after the accepting edge, count busy cycles until done
    task automatic wait_done(output int busy_cyc, output bit got);
        busy_cyc = 0;
        got      = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bus.done) got = 1'b1;
            else begin
                if (bus.busy) busy_cyc++;
                @(negedge clk);
            end
        end
    endtask

    task automatic check_result(input string name, input logic [31:0] ed, input logic ebo,
                                input logic eov, input int busy_cyc, input bit got);
        chk({name, "_done_seen"}, 32'(got), 32'd1);
        chk({name, "_busy_cycles"}, 32'(busy_cyc), 32'd4);
        chk({name, "_d"}, bus.d, ed);
        chk({name, "_bo"}, 32'(bus.bo), 32'(ebo));
        chk({name, "_ov"}, 32'(bus.ov), 32'(eov));
    endtask

    initial begin
        int          bc;
        bit          got;
        int          dones;
        logic [31:0] md;
        logic        mbo, mov;
        logic [31:0] ra, rb;
        logic        rbi;

        n_chk  = 0;
        n_fail = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bi    = 1'b0;

        vecs[0] = '{32'h0001_000F, 32'h0000_0001, 1'b0, 32'h0001_000E, 1'b0, 1'b0};
        vecs[1] = '{32'h1220_7E0A, 32'h0814_D1A0, 1'b0, 32'h0A0B_AC6A, 1'b0, 1'b0};
        vecs[2] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
        vecs[5] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        vecs[6] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1};

        // Reset for two cycles, then release
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_d", bus.d, 32'd0);
        chk("reset_bo", 32'(bus.bo), 32'd0);
        chk("reset_ov", 32'(bus.ov), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);

        // Directed vectors
        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].bi);
            wait_done(bc, got);
            check_result($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_bo,
                         vecs[i].exp_ov, bc, got);
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", i), 32'(bus.done), 32'd0);
        end

        // Results hold while idle
        repeat (3) @(negedge clk);
        chk("idle_hold_d", bus.d, vecs[6].exp_d);
        chk("idle_hold_bo", 32'(bus.bo), 32'(vecs[6].exp_bo));
        chk("idle_hold_busy", 32'(bus.busy), 32'd0);

        // start held through CALC with changing operands: one result, one done
        bus.start = 1'b1;
        bus.a     = 32'h0000_0100;
        bus.b     = 32'h0000_0001;
        bus.bi    = 1'b1;
        bc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.busy) bc++;
            bus.a  = $urandom;
            bus.b  = $urandom;
            bus.bi = 1'($urandom);
            if (i == 3) bus.start = 1'b0;
        end
        dones = 0;
        md    = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                md = bus.d;
            end
        end
        chk("held_start_busy_cycles", 32'(bc), 32'd4);
        chk("held_start_done_count", 32'(dones), 32'd1);
        chk("held_start_d", md, 32'h0000_00FE);

        // Back-to-back issue in the DONE cycle
        issue(32'h0000_0010, 32'h0000_0020, 1'b0);
        wait_done(bc, got);
        check_result("b2b_first", 32'hFFFF_FFF0, 1'b1, 1'b0, bc, got);
        issue(32'hC000_0000, 32'h4000_0000, 1'b0);
        chk("b2b_done_pulse", 32'(bus.done), 32'd0);
        wait_done(bc, got);
        check_result("b2b_second", 32'h8000_0000, 1'b0, 1'b0, bc, got);
        @(negedge clk);

        // Reset in CALC cycle 2 aborts and clears everything
        issue(32'h5555_5555, 32'h1111_1111, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_d", bus.d, 32'd0);
        chk("abort_bo", 32'(bus.bo), 32'd0);
        chk("abort_ov", 32'(bus.ov), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        chk("abort_no_done", 32'(dones), 32'd0);
        chk("abort_d_after", bus.d, 32'd0);

        // Randomized operands against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rbi = 1'($urandom);
            if (i % 8 == 0) rb = ra;
            if (i % 8 == 1) ra = {1'b1, 31'($urandom_range(0, 15))};
            model(ra, rb, rbi, md, mbo, mov);
            issue(ra, rb, rbi);
            wait_done(bc, got);
            check_result($sformatf("rand%0d", i), md, mbo, mov, bc, got);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sub_iter_clk.md
Name: sub_iter_clk

Overview:
- Clocked, multi-cycle 32-bit subtractor; the inverse-operation companion to the team's clocked CLA adder.
- Computes d = a - b - bi one SLICE-bit group per clock, using a SLICE-bit carry-lookahead slice on a + ~b + ~bi.
- Has a start/busy/done handshake so a controller can issue operands and collect the difference, borrow and overflow.
- Sits beside the adder in the datapath for ALU subtract operations.

Parameters:
- WIDTH, 32: operand and result width; must be an integer multiple of SLICE.
- SLICE, 8: bits processed per clock. NSLICE = WIDTH/SLICE.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  operation request; sampled on the rising edge.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- bi  input  1  borrow-in; captured on the accepting edge.
- d  output  WIDTH  difference, registered.
- bo  output  1  borrow-out, registered; 1 when a < b + bi (unsigned).
- ov  output  1  signed overflow, registered.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse when d, bo and ov are valid.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values: state=IDLE, d=0, bo=0, ov=0, busy=0, done=0. Slice counter and internal operand registers are also 0.
- Reset asserted mid-operation aborts immediately and returns to IDLE with all outputs 0. No partial result is retained.
- States: IDLE, CALC, DONE.
- IDLE, start=1 at an edge:
  - latch a, inverted b (nb = ~b), carry = ~bi; counter = 0.
  - go to CALC; busy=1 from the next cycle.
- IDLE, start=0: stay in IDLE; d/bo/ov hold their last values.
- CALC, each edge:
  - sum = a_slice[cnt] + nb_slice[cnt] + carry, computed by the SLICE-bit CLA.
  - write the low SLICE bits of sum into d slice cnt; carry = sum carry-out; cnt++.
  - d slice writes go directly to the d output register, so d is not valid before done.
- CALC, edge where cnt == NSLICE-1:
  - write the last slice.
  - bo = ~carry_out.
  - ov = (a[MSB] != b[MSB]) & (d[MSB] != a[MSB]), evaluated on the final d MSB.
  - go to DONE; busy=0, done=1.
- Latency: start accepted at edge 0, done high in the cycle following edge NSLICE (edge 4 at defaults).
- DONE: lasts exactly one cycle.
  - start=1: accept new operands, as from IDLE (back-to-back issue); done pulse is still one cycle.
  - start=0: go to IDLE; done=0.
- start while busy (CALC) is ignored; operand inputs are don't-care in CALC.
- Results (d, bo, ov) hold until the next accepted start begins overwriting d slices.
- Arithmetic is modulo 2^WIDTH. bi=1 subtracts one extra.
- Wrap-around cases: 0 - 1 gives all-ones with bo=1. a == b, bi=0 gives 0 with bo=0.

Test Plan:
- Reset sequence: reset=1 for 2 cycles, then release -> d=0, bo=0, ov=0, busy=0, done=0.
- Basic subtract: a=0x0001_000F, b=0x0000_0001, bi=0, start for 1 cycle -> busy high for 4 cycles; done on the 5th cycle after the start edge; d=0x0001_000E, bo=0, ov=0.
- Mixed-slice borrow chain: a=0x1220_7E0A, b=0x0814_D1A0, bi=0 -> d=0x0A0B_AC6A, bo=0, ov=0.
- Borrow and wrap:
  - a=0, b=1, bi=0 -> d=0xFFFF_FFFF, bo=1, ov=0.
  - then a=0xFFFF_FFFF, b=0xFFFF_FFFF, bi=1 -> d=0xFFFF_FFFF, bo=1.
- Signed overflow: a=0x8000_0000, b=0x0000_0001 -> d=0x7FFF_FFFF, ov=1, bo=0.
- Protocol corners:
  - start held through CALC: extra starts ignored; exactly one done.
  - start in the DONE cycle with new operands: second result after 4 more cycles.
  - reset pulsed during CALC cycle 2: outputs 0, state IDLE, no done pulse.
